// File: rtl/fibo_pkg.sv
// -----------------------------------------------------------------------------
// fibo_pkg
// Shared definitions for the Fibonacci controller and its datapath:
//   - data / address / opcode widths
//   - ALU opcode constants and register-file index constants
//   - controller state enum and the per-state control word decode
// -----------------------------------------------------------------------------
package fibo_pkg;

  localparam int FIBO_W_CNT  = 4;
  localparam int FIBO_W_ADDR = 2;
  localparam int FIBO_W_OP   = 3;

  typedef logic [FIBO_W_ADDR-1:0] addr_t;
  typedef logic [FIBO_W_OP-1:0]   op_t;

  localparam op_t OP_NOP   = 3'b000;
  localparam op_t OP_ONE   = 3'b001;  // result = 1
  localparam op_t OP_DEC   = 3'b011;  // result = A - 1
  localparam op_t OP_ADD   = 3'b110;  // result = A + B
  localparam op_t OP_PASSB = 3'b111;  // result = B

  localparam addr_t R_NUM0 = 2'd0;
  localparam addr_t R_NUM1 = 2'd1;
  localparam addr_t R_TMP  = 2'd2;
  localparam addr_t R_CNT  = 2'd3;

  typedef enum logic [3:0] {
    IDLE, LDCNT, INIT0, INIT1, MOV, ADD, SWP, DEC, DONE
  } state_e;

  // Datapath control word presented in each state (write enable handled apart).
  typedef struct packed {
    addr_t wa;
    logic  ld;
    addr_t ra1;
    addr_t ra2;
    op_t   op;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      LDCNT:   c = '{wa: R_CNT,  ld: 1'b1, ra1: R_NUM0, ra2: R_NUM0, op: OP_NOP};
      INIT0:   c = '{wa: R_NUM0, ld: 1'b0, ra1: R_NUM0, ra2: R_NUM0, op: OP_ONE};
      INIT1:   c = '{wa: R_NUM1, ld: 1'b0, ra1: R_NUM1, ra2: R_NUM0, op: OP_ONE};
      MOV:     c = '{wa: R_TMP,  ld: 1'b0, ra1: R_NUM0, ra2: R_NUM0, op: OP_PASSB};
      ADD:     c = '{wa: R_NUM0, ld: 1'b0, ra1: R_NUM0, ra2: R_NUM1, op: OP_ADD};
      SWP:     c = '{wa: R_NUM1, ld: 1'b0, ra1: R_NUM1, ra2: R_TMP,  op: OP_PASSB};
      DEC:     c = '{wa: R_CNT,  ld: 1'b0, ra1: R_CNT,  ra2: R_NUM0, op: OP_DEC};
      // DONE keeps R0 on the ALU output so data_out and the ALU agree.
      DONE:    c = '{wa: R_NUM0, ld: 1'b0, ra1: R_NUM0, ra2: R_NUM0, op: OP_PASSB};
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/FIBO_DATAPATH.sv
// -----------------------------------------------------------------------------
// FIBO_DATAPATH
// Four-entry register file (R0..R3) with a small ALU. One write per cycle.
// Ports:
//   Clk, Rst_n          clock, asynchronous active-low reset
//   wrt_adder, wrt_en   write address / enable
//   load_data           1 = write count, 0 = write ALU result
//   rd_addr1, rd_addr2  ALU operand A / B addresses
//   alu_opcode          ALU operation (OP_* in fibo_pkg)
//   count               external load value
//   zero_flag           ALU result == 0 (combinational)
//   data_out            R0
// -----------------------------------------------------------------------------
module FIBO_DATAPATH
  import fibo_pkg::*;
#(
  parameter int W_CNT  = FIBO_W_CNT,
  parameter int W_ADDR = FIBO_W_ADDR,
  parameter int W_OP   = FIBO_W_OP
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [W_ADDR-1:0] wrt_adder,
  input  logic              wrt_en,
  input  logic              load_data,
  input  logic [W_ADDR-1:0] rd_addr1,
  input  logic [W_ADDR-1:0] rd_addr2,
  input  logic [W_OP-1:0]   alu_opcode,
  input  logic [W_CNT-1:0]  count,
  output logic              zero_flag,
  output logic [W_CNT-1:0]  data_out
);

  logic [W_CNT-1:0] r_regs [2**W_ADDR];
  logic [W_CNT-1:0] w_a, w_b, w_alu, w_wdata;

  always_comb begin
    w_a = r_regs[rd_addr1];
    w_b = r_regs[rd_addr2];
    case (alu_opcode)
      OP_ONE:   w_alu = W_CNT'(1);
      OP_DEC:   w_alu = w_a - W_CNT'(1);
      OP_ADD:   w_alu = w_a + w_b;
      OP_PASSB: w_alu = w_b;
      default:  w_alu = '0;
    endcase
    w_wdata = load_data ? count : w_alu;
  end

  assign zero_flag = (w_alu == '0);
  assign data_out  = r_regs[R_NUM0];

  // NOTE: the register file is only four flops deep, so it is reset like any
  // other state; a large RAM would be left unreset instead.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 2**W_ADDR; i++) r_regs[i] <= '0;
    end else if (wrt_en) begin
      r_regs[wrt_adder] <= w_wdata;
    end
  end

endmodule

// File: rtl/fibo_controller.sv
// -----------------------------------------------------------------------------
// fibo_controller
// Sequences FIBO_DATAPATH to compute F(count+2), F(1)=F(2)=1:
//   R3<=count, R0<=1, R1<=1, then repeat {R2<=R0; R0<=R0+R1; R1<=R2; R3<=R3-1}
//   until the decrement result is zero. done is high while data_out holds R0.
// Ports:
//   Clk, Rst_n            clock, asynchronous active-low reset
//   start                 level request, sampled only in IDLE
//   count                 iteration count (zero-ness latched at acceptance)
//   zero_flag             datapath ALU result == 0
//   wrt_adder, wrt_en     datapath write address / enable
//   load_data             select external count as write data
//   rd_addr1, rd_addr2    ALU operand addresses
//   alu_opcode            ALU operation
//   busy                  high from start acceptance until DONE
//   done                  high in DONE
//   ovf                   only with FIBO_OVF_DETECT_EN: result exceeds 4 bits
// Configuration macro: FIBO_OVF_DETECT_EN
// -----------------------------------------------------------------------------
module fibo_controller
  import fibo_pkg::*;
#(
  parameter int W_CNT  = FIBO_W_CNT,
  parameter int W_ADDR = FIBO_W_ADDR,
  parameter int W_OP   = FIBO_W_OP
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              start,
  input  logic [W_CNT-1:0]  count,
  input  logic              zero_flag,
`ifdef FIBO_OVF_DETECT_EN
  output logic              ovf,
`endif
  output logic [W_ADDR-1:0] wrt_adder,
  output logic              wrt_en,
  output logic              load_data,
  output logic [W_ADDR-1:0] rd_addr1,
  output logic [W_ADDR-1:0] rd_addr2,
  output logic [W_OP-1:0]   alu_opcode,
  output logic              busy,
  output logic              done
);

  state_e r_state;
  logic   r_cnt_zero;  // count==0 at acceptance: skip the loop entirely
  ctrl_t  w_ctrl;
  logic   w_active;

  // NOTE: every register here is written with <= so all of them sample the
  // pre-edge values of one another.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= IDLE;
      r_cnt_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state    <= LDCNT;
          r_cnt_zero <= (count == '0);
        end
        LDCNT:   r_state <= INIT0;
        INIT0:   r_state <= INIT1;
        INIT1:   r_state <= r_cnt_zero ? DONE : MOV;
        MOV:     r_state <= ADD;
        ADD:     r_state <= SWP;
        SWP:     r_state <= DEC;
        // zero_flag reflects R3-1 computed this cycle, i.e. the last pass.
        DEC:     r_state <= zero_flag ? DONE : MOV;
        // Wait for start to drop so a held request cannot retrigger.
        DONE:    if (!start) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef FIBO_OVF_DETECT_EN
  // F(count+2) > 15 exactly when count+2 >= 8; extra bit avoids wrap at 14/15.
  logic r_ovf;
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_ovf <= (({1'b0, count} + (W_CNT+1)'(2)) >= (W_CNT+1)'(8));
    end else if (r_state == DONE && !start) begin
      r_ovf <= 1'b0;
    end
  end
  assign ovf = r_ovf;
`endif

  // NOTE: each signal gets its value at the top of the block, so no path
  // through it leaves a latch behind.
  always_comb begin
    w_ctrl   = state_ctrl(r_state);
    w_active = (r_state inside {LDCNT, INIT0, INIT1, MOV, ADD, SWP, DEC});
  end

  assign wrt_adder  = w_ctrl.wa;
  assign load_data  = w_ctrl.ld;
  assign rd_addr1   = w_ctrl.ra1;
  assign rd_addr2   = w_ctrl.ra2;
  assign alu_opcode = w_ctrl.op;
  assign wrt_en     = w_active;
  assign busy       = w_active;
  assign done       = (r_state == DONE);

endmodule

// File: tb/tb_fibo_controller.sv
// -----------------------------------------------------------------------------
// tb_fibo_controller
// fibo_controller driving FIBO_DATAPATH. Stimulus pushes the expected per-cycle
// control words and the expected result into queues; a monitor pops and
// compares them as the DUT presents outputs.
// -----------------------------------------------------------------------------
module tb_fibo_controller;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] count = 4'd0;
  logic       zero_flag, wrt_en, load_data, busy, done;
  logic [1:0] wrt_adder, rd_addr1, rd_addr2;
  logic [2:0] alu_opcode;
  logic [3:0] data_out;
`ifdef FIBO_OVF_DETECT_EN
  logic       ovf;
`endif

  fibo_controller u_ctrl (
    .Clk(Clk), .Rst_n(Rst_n), .start(start), .count(count), .zero_flag(zero_flag),
`ifdef FIBO_OVF_DETECT_EN
    .ovf(ovf),
`endif
    .wrt_adder(wrt_adder), .wrt_en(wrt_en), .load_data(load_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .alu_opcode(alu_opcode),
    .busy(busy), .done(done)
  );

  FIBO_DATAPATH u_dp (
    .Clk(Clk), .Rst_n(Rst_n), .wrt_adder(wrt_adder), .wrt_en(wrt_en),
    .load_data(load_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .alu_opcode(alu_opcode), .count(count), .zero_flag(zero_flag), .data_out(data_out)
  );

  always #100 Clk = ~Clk;

  // {wa, wen, ld, ra1, ra2, op, busy, done}
  logic [12:0] ctl_act;
  assign ctl_act = {wrt_adder, wrt_en, load_data, rd_addr1, rd_addr2, alu_opcode, busy, done};

  localparam logic [12:0] C_LDCNT = {2'd3, 1'b1, 1'b1, 2'd0, 2'd0, 3'b000, 1'b1, 1'b0};
  localparam logic [12:0] C_INIT0 = {2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 3'b001, 1'b1, 1'b0};
  localparam logic [12:0] C_INIT1 = {2'd1, 1'b1, 1'b0, 2'd1, 2'd0, 3'b001, 1'b1, 1'b0};
  localparam logic [12:0] C_MOV   = {2'd2, 1'b1, 1'b0, 2'd0, 2'd0, 3'b111, 1'b1, 1'b0};
  localparam logic [12:0] C_ADD   = {2'd0, 1'b1, 1'b0, 2'd0, 2'd1, 3'b110, 1'b1, 1'b0};
  localparam logic [12:0] C_SWP   = {2'd1, 1'b1, 1'b0, 2'd1, 2'd2, 3'b111, 1'b1, 1'b0};
  localparam logic [12:0] C_DEC   = {2'd3, 1'b1, 1'b0, 2'd3, 2'd0, 3'b011, 1'b1, 1'b0};
  localparam logic [12:0] C_DONE  = {2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 3'b111, 1'b0, 1'b1};

  typedef struct {
    logic [3:0] data;
    int         lat;
    logic       ovf;
  } exp_t;

  exp_t        exp_q[$];
  logic [12:0] ctl_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic prev_busy, prev_done;
    int   accept_cyc;
    exp_t e;
    prev_busy  = 1'b0;
    prev_done  = 1'b0;
    accept_cyc = 0;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        exp_q.delete();
        ctl_q.delete();
        prev_busy = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (busy && !prev_busy) accept_cyc = cyc;
        if (busy || (done && !prev_done)) begin
          if (ctl_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL ctl_unexpected actual=%0h expected=none (t=%0t)", ctl_act, $time);
          end else begin
            check("ctl_word", 32'(ctl_act), 32'(ctl_q.pop_front()));
          end
        end
        if (done && !prev_done) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL result_unexpected actual=%0h expected=none (t=%0t)", data_out, $time);
          end else begin
            e = exp_q.pop_front();
            check("data_out", 32'(data_out), 32'(e.data));
            check("latency", 32'(cyc - accept_cyc), 32'(e.lat));
`ifdef FIBO_OVF_DETECT_EN
            check("ovf", 32'(ovf), 32'(e.ovf));
`endif
          end
        end
        prev_busy = busy;
        prev_done = done;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_run(input logic [3:0] c, input logic [3:0] d, input int lat,
                          input logic o);
    exp_t e;
    e.data = d;
    e.lat  = lat;
    e.ovf  = o;
    exp_q.push_back(e);
    ctl_q.push_back(C_LDCNT);
    ctl_q.push_back(C_INIT0);
    ctl_q.push_back(C_INIT1);
    for (int i = 0; i < int'(c); i++) begin
      ctl_q.push_back(C_MOV);
      ctl_q.push_back(C_ADD);
      ctl_q.push_back(C_SWP);
      ctl_q.push_back(C_DEC);
    end
    ctl_q.push_back(C_DONE);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(posedge Clk); #1;
      n++;
    end
    check("done_within_budget", 32'(done), 32'd1);
  endtask

  // Called at posedge+1 with the controller in IDLE.
  task automatic run(input logic [3:0] c, input logic [3:0] d, input int lat,
                     input logic o, input bit hold);
    push_run(c, d, lat, o);
    count = c;
    start = 1'b1;
    @(posedge Clk); #1;          // acceptance edge
    if (!hold) start = 1'b0;
    @(posedge Clk); #1;          // R3 loaded from count
    count = ~c;                  // later changes must be ignored
    wait_done(lat + 4);
    if (!hold) begin
      @(posedge Clk); #1;
      check("back_to_idle", 32'({busy, done}), 32'd0);
`ifdef FIBO_OVF_DETECT_EN
      check("ovf_cleared", 32'(ovf), 32'd0);
`endif
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stimulus
    #250;
    check("reset_ctl", 32'(ctl_act), 32'd0);
    check("reset_data", 32'(data_out), 32'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    run(4'd4, 4'd8,  19, 1'b0, 1'b0);
    run(4'd5, 4'd13, 23, 1'b0, 1'b0);
    run(4'd0, 4'd1,   3, 1'b0, 1'b0);
    run(4'd6, 4'd5,  27, 1'b1, 1'b0);

    // Abort during ADD of the second iteration; its expectations get flushed.
    push_run(4'd5, 4'd13, 23, 1'b0);
    count = 4'd5;
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (8) @(posedge Clk);
    #50;
    Rst_n = 1'b0;
    #1;
    check("abort_ctl", 32'(ctl_act), 32'd0);
    check("abort_data", 32'(data_out), 32'd0);
    @(posedge Clk);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    check("post_reset_idle", 32'(ctl_act), 32'd0);
    run(4'd3, 4'd5, 15, 1'b0, 1'b0);

    // start held through DONE: no restart until it drops for a cycle.
    run(4'd2, 4'd3, 11, 1'b0, 1'b1);
    repeat (4) begin
      @(posedge Clk); #1;
      check("hold_in_done", 32'({busy, done}), 32'd1);
    end
    start = 1'b0;
    @(posedge Clk); #1;
    check("released_idle", 32'({busy, done}), 32'd0);
    run(4'd1, 4'd2, 7, 1'b0, 1'b0);

    repeat (2) @(posedge Clk);
    check("queues_drained", 32'(exp_q.size() + ctl_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #(200 * 5000);
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
